muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the MIPS EX stage. Operands come from the register file read ports (rs_data/rt_data). Results sit in HI/LO, which the EX/WB path reads for MFHI/MFLO and writes back through the register file write port. While an operation runs, busy stalls the pipeline through the hazard unit.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; results land 33 edges after start, busy stalls the pipe meanwhile.
// FAST_MUL_EN: multiplies finish in a single edge via a combinational multiplier; divides stay iterative.
`timescale 1ns/1ps
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   // MULT and DIV are the signed ops (op[0] clear)
   logic             is_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign is_signed = ~op[0];
   assign a_neg     = is_signed & rs_data[WIDTH-1];
   assign b_neg     = is_signed & rt_data[WIDTH-1];
   assign a_mag     = a_neg ? -rs_data : rs_data;
   assign b_mag     = b_neg ? -rt_data : rt_data;

   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_add  = acc_q[0] ? opb_q : {WIDTH{1'b0}};
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
   assign div_next = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
   assign fast_a    = {{WIDTH{a_neg}}, rs_data};
   assign fast_b    = {{WIDTH{b_neg}}, rt_data};
   assign fast_prod = fast_a * fast_b;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      dvd_d    = dvd_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               case (op)
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
                  OP_MULT, OP_MULTU: begin
`ifdef FAST_MUL_EN
                     {hi_d, lo_d} = fast_prod;
                     done_d       = 1'b1;
`else
                     state_d  = S_RUN;
                     cnt_d    = '0;
                     is_div_d = 1'b0;
                     neg_d    = a_neg ^ b_neg;
                     rneg_d   = 1'b0;
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     opb_d    = a_mag;
                     dvd_d    = rs_data;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d  = S_RUN;
                     cnt_d    = '0;
                     is_div_d = 1'b1;
                     neg_d    = a_neg ^ b_neg;
                     rneg_d   = a_neg;
                     acc_d    = {{WIDTH{1'b0}}, a_mag};
                     opb_d    = b_mag;
                     dvd_d    = rs_data;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
               end else if (opb_q == {WIDTH{1'b0}}) begin
                  lo_d = {WIDTH{1'b1}};
                  hi_d = dvd_q;
               end else begin
                  lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                  hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         dvd_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         dvd_q    <= dvd_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != S_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: iterative timing, signed/unsigned results, MTHI/MTLO, flush, async reset.
`timescale 1ns/1ps
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] rs_data, rt_data;
   logic         flush;
   logic [W-1:0] hi, lo;
   logic         busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge; inputs settle 1ns after the edge
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      step();
      start   = 1'b0;
      op      = 3'b111;
   endtask

   // Returns at the first sample with busy low; counts busy samples and done pulses seen
   task automatic wait_idle(output int busy_cyc, output int done_cnt);
      busy_cyc = 0;
      done_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         if (!busy) break;
         busy_cyc++;
         step();
         if (done) done_cnt++;
      end
   endtask

   int bc, dc;

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b111;
      rs_data = '0; rt_data = '0;
      #12;
      check_val("rst_hi", hi, 0);
      check_val("rst_lo", lo, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      #3 reset = 1'b0;
      step();

      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_val("multu_busy_e0", busy, 1);
      wait_idle(bc, dc);
      check_val("multu_busy_cycles", bc, 33);
      check_val("multu_done_pulses", dc, 1);
      check_val("multu_hi", hi, 64'hFFFF_FFFE);
      check_val("multu_lo", lo, 64'h0000_0001);
      step();
      check_val("multu_done_drop", done, 0);

      issue(3'b000, 32'hFFFF_FFFD, 32'd7);
      wait_idle(bc, dc);
      check_val("mult_hi", hi, 64'hFFFF_FFFF);
      check_val("mult_lo", lo, 64'hFFFF_FFEB);

      // Chained: each new request goes in during the done cycle
      issue(3'b010, 32'hFFFF_FFF9, 32'd2);
      wait_idle(bc, dc);
      check_val("div_neg_lo", lo, 64'hFFFF_FFFD);
      check_val("div_neg_hi", hi, 64'hFFFF_FFFF);
      check_val("div_neg_done", done, 1);
      issue(3'b011, 32'd7, 32'd0);
      check_val("b2b_accept_busy", busy, 1);
      wait_idle(bc, dc);
      check_val("divu_z_cycles", bc, 33);
      check_val("divu_z_lo", lo, 64'hFFFF_FFFF);
      check_val("divu_z_hi", hi, 64'h7);
      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(bc, dc);
      check_val("div_ovf_lo", lo, 64'h8000_0000);
      check_val("div_ovf_hi", hi, 64'h0);
      issue(3'b010, 32'd7, 32'hFFFF_FFFE);
      wait_idle(bc, dc);
      check_val("div_negdiv_lo", lo, 64'hFFFF_FFFD);
      check_val("div_negdiv_hi", hi, 64'h1);

      issue(3'b100, 32'h1234_5678, 32'd0);
      check_val("mthi_hi", hi, 64'h1234_5678);
      check_val("mthi_busy", busy, 0);
      issue(3'b101, 32'h9ABC_DEF0, 32'd0);
      check_val("mtlo_lo", lo, 64'h9ABC_DEF0);
      check_val("mtlo_hi_keep", hi, 64'h1234_5678);
      check_val("mtlo_busy", busy, 0);
      check_val("mtlo_done", done, 0);

      issue(3'b110, 32'h5555_1111, 32'd3);
      check_val("undef_busy", busy, 0);
      check_val("undef_hi", hi, 64'h1234_5678);
      check_val("undef_lo", lo, 64'h9ABC_DEF0);

      issue(3'b011, 32'd100, 32'd3);
      repeat (4) step();
      issue(3'b100, 32'hDEAD_BEEF, 32'd0);
      check_val("mthi_busy_ignored", hi, 64'h1234_5678);
      wait_idle(bc, dc);
      check_val("divu100_lo", lo, 64'd33);
      check_val("divu100_hi", hi, 64'd1);

      issue(3'b100, 32'h0000_AAAA, 32'd0);
      issue(3'b101, 32'h0000_5555, 32'd0);
      issue(3'b011, 32'd100, 32'd3);
      repeat (9) step();
      check_val("pre_flush_busy", busy, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_val("flush_busy", busy, 0);
      check_val("flush_done", done, 0);
      check_val("flush_hi", hi, 64'h0000_AAAA);
      check_val("flush_lo", lo, 64'h0000_5555);
      issue(3'b011, 32'd100, 32'd7);
      check_val("post_flush_accept", busy, 1);
      wait_idle(bc, dc);
      check_val("post_flush_cycles", bc, 33);
      check_val("post_flush_lo", lo, 64'd14);
      check_val("post_flush_hi", hi, 64'd2);

      // flush alongside start in IDLE drops the request
      flush = 1'b1;
      issue(3'b100, 32'h7777_7777, 32'd0);
      flush = 1'b0;
      check_val("flush_idle_hi", hi, 64'd2);

      issue(3'b001, 32'h0001_0000, 32'h0001_0000);
      repeat (14) step();
      #2 reset = 1'b1;
      #1;
      check_val("arst_hi", hi, 0);
      check_val("arst_lo", lo, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_done", done, 0);
      #4 reset = 1'b0;
      step();
      issue(3'b001, 32'h1234_5678, 32'h0000_0100);
      wait_idle(bc, dc);
      check_val("rerun_cycles", bc, 33);
      check_val("rerun_done", dc, 1);
      check_val("rerun_hi", hi, 64'h12);
      check_val("rerun_lo", lo, 64'h3456_7800);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
